// File: rtl/register_swap_sorter.sv
// Block sorter: loads DEPTH words, bubble-sorts them in place with one
// compare-exchange per clock, then streams the sorted block out over valid/ready.
module register_swap_sorter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_swap_count
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_CMP = PTR_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_cmp;
  logic [PTR_W-1:0] r_pass;
  logic             r_swapped;
  logic [CNT_W-1:0] r_swap_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_busy;

  logic [PTR_W-1:0] w_cmp_hi;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic             w_swap;
  logic             w_pass_end;
  logic             w_sort_done;
  logic [WIDTH-1:0] w_first;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Compare-exchange datapath; the end-of-pass decision includes this cycle's swap.
  always_comb begin
    w_cmp_hi    = r_cmp + PTR_W'(1);
    w_rd_nxt    = r_rd_ptr + PTR_W'(1);
    w_lo        = r_mem[r_cmp];
    w_hi        = r_mem[w_cmp_hi];
    w_swap      = (r_state == S_SORT) && (w_lo > w_hi);
    w_pass_end  = (r_cmp == LAST_CMP);
    w_sort_done = w_pass_end && (!(r_swapped || w_swap) || (r_pass == LAST_CMP));
    w_first     = (w_swap && (r_cmp == '0)) ? w_hi : r_mem[0];
    w_in_xfer   = i_in_valid & r_in_ready;
    w_out_xfer  = r_out_valid & i_out_ready;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_LOAD;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cmp        <= '0;
      r_pass       <= '0;
      r_swapped    <= 1'b0;
      r_swap_count <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_xfer) begin
            r_mem[r_wr_ptr] <= i_in_data;
            if (r_wr_ptr == '0) r_swap_count <= '0;
            if (r_wr_ptr == LAST_IDX) begin
              r_state    <= S_SORT;
              r_wr_ptr   <= '0;
              r_cmp      <= '0;
              r_pass     <= '0;
              r_swapped  <= 1'b0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
          end
        end
        S_SORT: begin
          // Both registers update on the same edge from the pre-edge values.
          if (w_swap) begin
            r_mem[r_cmp]    <= w_hi;
            r_mem[w_cmp_hi] <= w_lo;
            r_swapped       <= 1'b1;
            if (r_swap_count != CNT_MAX) r_swap_count <= r_swap_count + CNT_W'(1);
          end
          if (w_pass_end) begin
            r_cmp <= '0;
            if (w_sort_done) begin
              r_state     <= S_DRAIN;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_first;
              r_rd_ptr    <= '0;
            end else begin
              r_pass    <= r_pass + PTR_W'(1);
              r_swapped <= 1'b0;
            end
          end else begin
            r_cmp <= w_cmp_hi;
          end
        end
        S_DRAIN: begin
          if (w_out_xfer) begin
            if (r_rd_ptr == LAST_IDX) begin
              r_state     <= S_LOAD;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_rd_ptr    <= '0;
              r_wr_ptr    <= '0;
            end else begin
              r_rd_ptr   <= w_rd_nxt;
              r_out_data <= r_mem[w_rd_nxt];
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_busy       = r_busy;
  assign o_swap_count = r_swap_count;

endmodule
